calc_scoreboard: RTL
====================

Name: calc_scoreboard

Overview:
- Parametrised, latency-tolerant scoreboard for the calculator verification environment.
- Captures every non-idle response from the reference model and from the DUV into per-port in-order queues, then compares head entries pairwise.
- Reference and DUV may respond on different cycles. Mismatches, missing responses (timeout) and queue overflow are counted and flagged per port.
- Sits alongside the bench, sampling both models' output buses on c_clk.

Parameters:
NUM_PORTS, 4, number of request/response channels
DATA_W, 32, width of each out_data field
RESP_W, 2, width of each out_resp field; value 0 means no response
DEPTH, 8, entries per queue per side (power of 2, >=2)
TIMEOUT, 64, cycles a lone head entry may wait for its partner
CNT_W, 16, width of the saturating statistics counters
MASK_DATA_ON_ERR, 1, 1 = data compared only when both resp equal SUCC_CODE
SUCC_CODE, 1, response code that carries valid data

Ports:
c_clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous active-high reset
clear  input  1  synchronous clear of counters and sticky flags only (queues untouched)
ref_out_data  input  NUM_PORTS*DATA_W  reference data, port p at [p*DATA_W +: DATA_W]
ref_out_resp  input  NUM_PORTS*RESP_W  reference response, same packing
duv_out_data  input  NUM_PORTS*DATA_W  DUV data
duv_out_resp  input  NUM_PORTS*RESP_W  DUV response
match_pulse  output  NUM_PORTS  1-cycle pulse: head pair compared equal
mismatch_pulse  output  NUM_PORTS  1-cycle pulse: head pair compared unequal
timeout_pulse  output  NUM_PORTS  1-cycle pulse: lone head dropped after TIMEOUT
overflow_flag  output  NUM_PORTS  sticky: a push hit a full queue
cmp_count  output  CNT_W  total comparisons, saturating
err_count  output  CNT_W  mismatches + timeouts + overflow drops, saturating
pass  output  1  err_count==0, no overflow_flag, all queues empty

Behaviour:
- Reset: all queues empty, timeout counters 0, all pulses 0, overflow_flag 0, counters 0, pass 1.
- Push: in a cycle where resp field of port p != 0, {data,resp} is pushed into that side's queue p. Ref and DUV push independently.
- Push accepted if the queue is not full, or if the queue pops in the same cycle. Otherwise the entry is dropped, overflow_flag[p] is set and err_count increments.
- Compare: when both queues of port p are non-empty at a rising edge, both heads pop and are compared.
  - Pulse appears the following cycle; minimum push-to-pulse latency is 2 cycles (push at N, compare at N+1, registered pulse visible N+1 to N+2).
  - Entries pushed at N are never compared at N (no bypass).
- Equality: resp must match. Data must also match unless MASK_DATA_ON_ERR=1 and either resp != SUCC_CODE.
- Each compare increments cmp_count; each mismatch also increments err_count.
- Timeout FSM per port, states IDLE/WAIT:
  - IDLE -> WAIT when exactly one side is non-empty and no compare occurs; counter loads 1.
  - In WAIT, the counter increments each cycle while the condition holds.
  - WAIT -> IDLE on a compare or when both sides are empty; counter cleared.
  - When the counter reaches TIMEOUT: pop the lone head, pulse timeout_pulse[p], increment err_count, return to IDLE.
- Multiple events on the same cycle (several ports, plus an overflow) increment err_count by their total count, saturating at 2^CNT_W-1. cmp_count likewise.
- clear and reset in the same cycle: reset wins. clear zeroes counters and overflow_flag; pulses, queues and FSMs are unaffected.
- Reset mid-operation flushes all pending entries with no pulses and no counting.
- Queue pointers wrap modulo DEPTH; full/empty are distinguished by an extra pointer bit.

Test Plan:
- Same-cycle push on port 1: ref and DUV both resp=1, data=0x0000_0005 at cycle N -> match_pulse[0] at N+1 to N+2; cmp_count=1, err_count=0, pass=1.
- Skewed latency on port 3: ref resp=1/data=0xA at N, DUV resp=1/data=0xA at N+5 -> single match_pulse[2]; no timeout; err_count=0.
- Data masking: port 2, both resp=2 with data 0x1 vs 0xFFFF_FFFF; MASK_DATA_ON_ERR=1 -> match. Rebuild with MASK_DATA_ON_ERR=0 -> mismatch_pulse[1], err_count=1, pass=0.
- Missing DUV response: TIMEOUT=4, ref resp=1 on port 4, DUV silent -> timeout_pulse[3] exactly 4 cycles after the entry becomes lone head; err_count=1; queue empty afterwards.
- Overflow: DEPTH=8, 9 consecutive ref pushes on port 1, DUV silent, TIMEOUT large -> overflow_flag[0]=1 on the 9th, err_count=1. clear -> flag 0, err_count 0.
- Reset mid-stream: 3 ref entries pending on port 1, assert reset for 1 cycle -> no pulses, counters 0, pass=1. A later matching pair compares as a fresh first entry.

Source files
------------

// File: rtl/calc_scoreboard.sv
// Latency-tolerant in-order scoreboard: per-port reference/DUV queues with pairwise head
// compare, lone-head timeout, overflow detection and saturating statistics.
module calc_scoreboard #(
    parameter int NUM_PORTS        = 4,
    parameter int DATA_W           = 32,
    parameter int RESP_W           = 2,
    parameter int DEPTH            = 8,
    parameter int TIMEOUT          = 64,
    parameter int CNT_W            = 16,
    parameter int MASK_DATA_ON_ERR = 1,
    parameter int SUCC_CODE        = 1
) (
    input  logic                        c_clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic [NUM_PORTS*DATA_W-1:0] ref_out_data,
    input  logic [NUM_PORTS*RESP_W-1:0] ref_out_resp,
    input  logic [NUM_PORTS*DATA_W-1:0] duv_out_data,
    input  logic [NUM_PORTS*RESP_W-1:0] duv_out_resp,
    output logic [NUM_PORTS-1:0]        match_pulse,
    output logic [NUM_PORTS-1:0]        mismatch_pulse,
    output logic [NUM_PORTS-1:0]        timeout_pulse,
    output logic [NUM_PORTS-1:0]        overflow_flag,
    output logic [CNT_W-1:0]            cmp_count,
    output logic [CNT_W-1:0]            err_count,
    output logic                        pass
);
    // state   | meaning
    // IDLE    | no lone head pending (both queues empty, or a compare this cycle)
    // WAIT    | exactly one side holds entries; wait_cnt counts cycles alone
    typedef enum logic {ST_IDLE, ST_WAIT} wait_state_t;

    localparam int AW    = $clog2(DEPTH);
    localparam int PW    = AW + 1;
    localparam int ENT_W = DATA_W + RESP_W;
    localparam int TW    = $clog2(TIMEOUT + 1);

    logic [NUM_PORTS-1:0] do_cmp, cmp_eq, to_fire, ref_ovf, duv_ovf, ref_empty, duv_empty;
    logic [CNT_W-1:0]     cmp_inc, err_inc, cmp_nxt, err_nxt;
    logic [CNT_W:0]       cmp_sum, err_sum;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic [ENT_W-1:0]  ref_mem [DEPTH];
        logic [ENT_W-1:0]  duv_mem [DEPTH];
        logic [PW-1:0]     ref_wr, ref_rd, duv_wr, duv_rd;
        logic [RESP_W-1:0] ref_resp_in, duv_resp_in;
        logic [RESP_W-1:0] ref_head_resp, duv_head_resp;
        logic [ENT_W-1:0]  ref_head, duv_head;
        logic              ref_full, duv_full, ref_pop, duv_pop;
        logic              ref_push_ok, duv_push_ok, lone, data_care, fire;
        wait_state_t       st, st_nxt;
        logic [TW-1:0]     wait_cnt, wait_cnt_nxt;

        assign ref_resp_in = ref_out_resp[p*RESP_W +: RESP_W];
        assign duv_resp_in = duv_out_resp[p*RESP_W +: RESP_W];

        // Extra pointer bit tells full from empty when the index bits coincide.
        assign ref_empty[p] = (ref_wr == ref_rd);
        assign duv_empty[p] = (duv_wr == duv_rd);
        assign ref_full = (ref_wr[AW] != ref_rd[AW]) && (ref_wr[AW-1:0] == ref_rd[AW-1:0]);
        assign duv_full = (duv_wr[AW] != duv_rd[AW]) && (duv_wr[AW-1:0] == duv_rd[AW-1:0]);

        assign do_cmp[p] = ~ref_empty[p] & ~duv_empty[p];
        assign lone      = ref_empty[p] ^ duv_empty[p];
        assign ref_pop   = do_cmp[p] | (fire & ~ref_empty[p]);
        assign duv_pop   = do_cmp[p] | (fire & ~duv_empty[p]);

        assign ref_push_ok = (|ref_resp_in) & (~ref_full | ref_pop);
        assign duv_push_ok = (|duv_resp_in) & (~duv_full | duv_pop);
        assign ref_ovf[p]  = (|ref_resp_in) & ~ref_push_ok;
        assign duv_ovf[p]  = (|duv_resp_in) & ~duv_push_ok;

        assign ref_head      = ref_mem[ref_rd[AW-1:0]];
        assign duv_head      = duv_mem[duv_rd[AW-1:0]];
        assign ref_head_resp = ref_head[ENT_W-1 -: RESP_W];
        assign duv_head_resp = duv_head[ENT_W-1 -: RESP_W];

        assign data_care = (MASK_DATA_ON_ERR == 0) ||
                           ((ref_head_resp == RESP_W'(SUCC_CODE)) &&
                            (duv_head_resp == RESP_W'(SUCC_CODE)));
        assign cmp_eq[p] = (ref_head_resp == duv_head_resp) &&
                           (!data_care || (ref_head[DATA_W-1:0] == duv_head[DATA_W-1:0]));
        assign to_fire[p] = fire;

        always_ff @(posedge c_clk) begin
            if (ref_push_ok) ref_mem[ref_wr[AW-1:0]] <= {ref_resp_in, ref_out_data[p*DATA_W +: DATA_W]};
            if (duv_push_ok) duv_mem[duv_wr[AW-1:0]] <= {duv_resp_in, duv_out_data[p*DATA_W +: DATA_W]};
        end

        always_ff @(posedge c_clk) begin
            if (reset) begin
                ref_wr   <= '0;
                ref_rd   <= '0;
                duv_wr   <= '0;
                duv_rd   <= '0;
                st       <= ST_IDLE;
                wait_cnt <= '0;
            end else begin
                if (ref_push_ok) ref_wr <= ref_wr + PW'(1);
                if (ref_pop)     ref_rd <= ref_rd + PW'(1);
                if (duv_push_ok) duv_wr <= duv_wr + PW'(1);
                if (duv_pop)     duv_rd <= duv_rd + PW'(1);
                st       <= st_nxt;
                wait_cnt <= wait_cnt_nxt;
            end
        end

        // The head is dropped on the cycle its lone count would reach TIMEOUT.
        always_comb begin
            st_nxt       = st;
            wait_cnt_nxt = wait_cnt;
            fire         = 1'b0;
            case (st)
                ST_IDLE: begin
                    if (lone) begin
                        if (TIMEOUT <= 1) begin
                            fire = 1'b1;
                        end else begin
                            st_nxt       = ST_WAIT;
                            wait_cnt_nxt = TW'(1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (!lone) begin
                        st_nxt       = ST_IDLE;
                        wait_cnt_nxt = '0;
                    end else if (wait_cnt >= TW'(TIMEOUT - 1)) begin
                        fire         = 1'b1;
                        st_nxt       = ST_IDLE;
                        wait_cnt_nxt = '0;
                    end else begin
                        wait_cnt_nxt = wait_cnt + TW'(1);
                    end
                end
                default: begin
                    st_nxt       = ST_IDLE;
                    wait_cnt_nxt = '0;
                end
            endcase
        end
    end

    always_comb begin
        cmp_inc = '0;
        err_inc = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cmp_inc = cmp_inc + CNT_W'(do_cmp[i]);
            err_inc = err_inc + CNT_W'(do_cmp[i] & ~cmp_eq[i]) + CNT_W'(to_fire[i])
                              + CNT_W'(ref_ovf[i]) + CNT_W'(duv_ovf[i]);
        end
    end

    assign cmp_sum = {1'b0, cmp_count} + {1'b0, cmp_inc};
    assign err_sum = {1'b0, err_count} + {1'b0, err_inc};
    assign cmp_nxt = cmp_sum[CNT_W] ? '1 : cmp_sum[CNT_W-1:0];
    assign err_nxt = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];

    // clear takes priority over any event counted in the same cycle.
    always_ff @(posedge c_clk) begin
        if (reset) begin
            match_pulse    <= '0;
            mismatch_pulse <= '0;
            timeout_pulse  <= '0;
            overflow_flag  <= '0;
            cmp_count      <= '0;
            err_count      <= '0;
        end else begin
            match_pulse    <= do_cmp & cmp_eq;
            mismatch_pulse <= do_cmp & ~cmp_eq;
            timeout_pulse  <= to_fire;
            if (clear) begin
                overflow_flag <= '0;
                cmp_count     <= '0;
                err_count     <= '0;
            end else begin
                overflow_flag <= overflow_flag | ref_ovf | duv_ovf;
                cmp_count     <= cmp_nxt;
                err_count     <= err_nxt;
            end
        end
    end

    assign pass = (err_count == '0) && (overflow_flag == '0) && (&(ref_empty & duv_empty));

endmodule
